mul_div_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It sits beside the single-cycle ALU in the execute stage and implements MIPS mult/multu/div/divu plus mthi/mtlo. Operations are issued through a valid/ready handshake; the pipeline stalls on `busy` and can flush an in-flight operation via `cancel`. The multiplier has a configurable latency, and the divider is iterative, retiring one quotient bit per cycle.

---
 rtl/mul_div_pkg.sv | 16 +
 rtl/mul_div_unit_if.sv | 28 ++
 rtl/mul_div_divider.sv | 67 ++++++
 rtl/mul_div_unit.sv | 143 ++++++++++++++
 tb/tb_mul_div_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mul_div_pkg.sv
// Shared op-bit positions, FSM state type and a one-hot helper for the
// multiply/divide unit.
package mul_div_pkg;

  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/flush/mthi-mtlo bus between the execute stage and the mul/div unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             request_valid;
  logic             request_ready;
  logic [3:0]       request_operation;
  logic [WIDTH-1:0] request_input_1;
  logic [WIDTH-1:0] request_input_2;
  logic             cancel;
  logic             write_hi;
  logic             write_lo;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output request_valid, request_operation, request_input_1, request_input_2,
           cancel, write_hi, write_lo, write_data,
    input  request_ready, hi, lo, busy, done
  );

  modport slave (
    input  request_valid, request_operation, request_input_1, request_input_2,
           cancel, write_hi, write_lo, write_data,
    output request_ready, hi, lo, busy, done
  );
endinterface

// File: rtl/mul_div_divider.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per
// step, last_o once WIDTH steps have been retired since start_i.
module mul_div_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             last_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   shifted, diff;

  assign last_o      = (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  // Partial remainder is one bit wider so the trial subtract's borrow is exact.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (start_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = CW'(WIDTH);
    end else if (step_i && !last_o) begin
      cnt_d = cnt_q - CW'(1);
      if (!diff[WIDTH]) begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mul_div_unit.sv
// MIPS mult/multu/div/divu with architectural HI/LO: fixed-latency multiply,
// iterative divide plus one sign-fix cycle, cancellable while busy.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic           clock,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);
  localparam int CWM = $clog2(MUL_CYCLES + 1);

  state_e           state_q, state_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CWM-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             accept, req_mul, req_div, req_sgn_div;
  logic [2*WIDTH-1:0] ext_a, ext_b, product;
  logic             div_start, div_step, div_last;
  logic [WIDTH-1:0] div_quo, div_rem, quo_fix, rem_fix;
  logic             q_neg, r_neg;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  assign bus.request_ready = (state_q == IDLE) && !bus.cancel;
  assign bus.busy          = (state_q != IDLE);
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;
  assign bus.done          = done_q;

  assign accept      = bus.request_valid && bus.request_ready && is_onehot4(bus.request_operation);
  assign req_mul     = bus.request_operation[OP_MULT] | bus.request_operation[OP_MULTU];
  assign req_div     = bus.request_operation[OP_DIV]  | bus.request_operation[OP_DIVU];
  assign req_sgn_div = bus.request_operation[OP_DIV];

  // Full 2W-by-2W multiply on extended operands gives both signed and unsigned products.
  assign ext_a   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b   = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign product = ext_a * ext_b;

  assign div_start = accept && req_div;
  assign div_step  = (state_q == DIV) && !bus.cancel;

  mul_div_divider #(.WIDTH(WIDTH)) u_div (
    .clock       (clock),
    .reset       (reset),
    .start_i     (div_start),
    .step_i      (div_step),
    .dividend_i  (mag(bus.request_input_1, req_sgn_div)),
    .divisor_i   (mag(bus.request_input_2, req_sgn_div)),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .last_o      (div_last)
  );

  assign q_neg   = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign r_neg   = sgn_q && a_q[WIDTH-1];
  assign quo_fix = q_neg ? -div_quo : div_quo;
  assign rem_fix = r_neg ? -div_rem : div_rem;

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (bus.write_hi) hi_d = bus.write_data;
    if (bus.write_lo) lo_d = bus.write_data;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sgn_d = bus.request_operation[OP_MULT] | bus.request_operation[OP_DIV];
          a_d   = bus.request_input_1;
          b_d   = bus.request_input_2;
          cnt_d = CWM'(MUL_CYCLES - 1);
          state_d = req_mul ? MUL : DIV;
        end
      end
      MUL: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = product;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CWM'(1);
        end
      end
      DIV: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else if (div_last) begin
          // Zero divisor bypasses the core; MIN/-1 falls out of the magnitude path.
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench: vector table through a result scoreboard, then
// hand-built cancel/reset/race/back-to-back sequences.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_div_unit_if #(.WIDTH(32)) bus ();
  mul_div_unit #(.WIDTH(32), .MUL_CYCLES(2)) dut (.clock(clk), .reset(rst), .bus(bus));

  localparam logic [3:0] MULT = 4'b0001, MULTU = 4'b0010, DIV = 4'b0100, DIVU = 4'b1000;

  typedef struct { logic [3:0] op; logic [31:0] a, b, ehi, elo; int lat; } vec_t;
  typedef struct { logic [31:0] hi, lo; int lat; int acc; } exp_t;
  exp_t sb[$];
  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat, input bit push);
    exp_t e;
    bus.request_valid = 1'b1;
    bus.request_operation = op;
    bus.request_input_1 = a;
    bus.request_input_2 = b;
    @(posedge clk);
    #1;
    bus.request_valid = 1'b0;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, input int bound, input bit chk_busy);
    exp_t e;
    bit seen = 1'b0;
    int busy_low = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          chk({name, " spurious_done"}, 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk({name, " hi"}, {32'd0, bus.hi}, {32'd0, e.hi});
          chk({name, " lo"}, {32'd0, bus.lo}, {32'd0, e.lo});
          chk({name, " latency"}, 64'(cyc - e.acc), 64'(e.lat));
        end
      end else if (!bus.busy) begin
        busy_low++;
      end
    end
    if (!seen) begin
      chk({name, " timeout"}, 64'd0, 64'd1);
      sb.delete();
    end
    if (chk_busy) chk({name, " busy_held"}, 64'(busy_low), 64'd0);
  endtask

  task automatic count_done(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk({name, " no_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 2};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 33};
    vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};
    vecs[5]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[6]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vecs[7]  = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        33};
    vecs[8]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        2};
    vecs[9]  = '{DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 33};
    vecs[10] = '{DIVU,  32'hFFFFFFFF, 32'd2,        32'd1,        32'h7FFFFFFF, 33};
    vecs[11] = '{MULTU, 32'h12345678, 32'h10,       32'd1,        32'h23456780, 2};
    vecs[12] = '{MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 2};
    vecs[13] = '{DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        33};

    bus.request_valid = 1'b0; bus.request_operation = 4'd0;
    bus.request_input_1 = '0; bus.request_input_2 = '0;
    bus.cancel = 1'b0; bus.write_hi = 1'b0; bus.write_lo = 1'b0; bus.write_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("reset hi",    {32'd0, bus.hi}, 64'd0);
    chk("reset lo",    {32'd0, bus.lo}, 64'd0);
    chk("reset done",  64'(bus.done), 64'd0);
    chk("reset busy",  64'(bus.busy), 64'd0);
    chk("reset ready", 64'(bus.request_ready), 64'd1);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].lat, 1'b1);
      wait_done($sformatf("vec%0d", i), 60, 1'b1);
    end

    // back-to-back issue in the done cycle
    @(negedge clk);
    issue(MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 2, 1'b1);
    wait_done("b2b_first", 10, 1'b1);
    chk("b2b ready_in_done", 64'(bus.request_ready), 64'd1);
    issue(MULT, 32'd7, 32'd7, 32'd0, 32'd49, 2, 1'b1);
    wait_done("b2b_second", 10, 1'b1);

    // cancel a divide at cycle 10 with HI/LO preloaded
    @(negedge clk); bus.write_hi = 1'b1; bus.write_data = 32'h11;
    @(negedge clk); bus.write_hi = 1'b0; bus.write_lo = 1'b1; bus.write_data = 32'h22;
    @(negedge clk); bus.write_lo = 1'b0;
    chk("mthi", {32'd0, bus.hi}, 64'h11);
    chk("mtlo", {32'd0, bus.lo}, 64'h22);
    issue(DIV, 32'd1000, 32'd3, 32'd0, 32'd0, 0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk) bus.cancel = 1'b1;
    @(posedge clk); #1 bus.cancel = 1'b0;
    @(negedge clk);
    chk("cancel busy",  64'(bus.busy), 64'd0);
    chk("cancel ready", 64'(bus.request_ready), 64'd1);
    count_done("cancel", 40);
    chk("cancel hi", {32'd0, bus.hi}, 64'h11);
    chk("cancel lo", {32'd0, bus.lo}, 64'h22);

    // reset mid-multiply
    @(negedge clk);
    issue(MULTU, 32'd3, 32'd4, 32'd0, 32'd0, 0, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid hi",   {32'd0, bus.hi}, 64'd0);
    chk("rst_mid lo",   {32'd0, bus.lo}, 64'd0);
    chk("rst_mid busy", 64'(bus.busy), 64'd0);
    chk("rst_mid done", 64'(bus.done), 64'd0);
    count_done("rst_mid", 5);

    // mtlo on the completion edge loses to the product
    @(negedge clk);
    issue(MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 2, 1'b1);
    @(negedge clk); bus.write_lo = 1'b1; bus.write_data = 32'hDEAD;
    wait_done("mtlo_race", 10, 1'b0);
    bus.write_lo = 1'b0;
    @(negedge clk);
    chk("mtlo_race lo_after", {32'd0, bus.lo}, 64'd42);

    // cancel in IDLE blocks acceptance
    @(negedge clk);
    bus.cancel = 1'b1; bus.request_valid = 1'b1; bus.request_operation = MULT;
    bus.request_input_1 = 32'd2; bus.request_input_2 = 32'd3;
    #1 chk("idle_cancel ready", 64'(bus.request_ready), 64'd0);
    @(posedge clk); #1 bus.request_valid = 1'b0; bus.cancel = 1'b0;
    chk("idle_cancel busy", 64'(bus.busy), 64'd0);
    count_done("idle_cancel", 5);

    // invalid op encodings are ignored
    @(negedge clk);
    issue(4'b0011, 32'd2, 32'd3, 32'd0, 32'd0, 0, 1'b0);
    chk("multi_bit busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    issue(4'b0000, 32'd2, 32'd3, 32'd0, 32'd0, 0, 1'b0);
    chk("zero_op busy", 64'(bus.busy), 64'd0);
    count_done("bad_op", 5);

    @(negedge clk);
    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
